dmem_ctrl: RTL and testbench

- Load/store controller in front of the byte-lane data memory: four 8-bit synchronous RAMs, 1-cycle read latency, one write enable per lane.
- Decodes RV32I load/store width (funct3) into lane enables, replicates store data onto lanes, and extracts plus sign/zero-extends load data.
- Flags misaligned or illegal accesses.
- Arbitrates the memory between the CPU data port and a word-wide loader/debug port, round-robin.

---
 rtl/dmem_ctrl_if.sv | 42 ++++
 rtl/dmem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Bundle of the CPU data port, loader/debug port and byte-lane memory port seen by dmem_ctrl.
// slave is the controller's view; master is the requesters' plus memory's view.
interface dmem_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_fault;

  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic [31:0] ld_rdata;
  logic        ld_valid;

  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic [31:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_fault,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_valid,
    output mem_addr, mem_wd, mem_be,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_fault,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_valid,
    input  mem_addr, mem_wd, mem_be,
    output mem_rd
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Load/store controller for a 4-lane byte memory with 1-cycle read latency.
// Round-robin arbitration between CPU data port and word-wide loader port.
module dmem_ctrl #(
  parameter int unsigned AW = 10
) (
  input  logic       clk,
  input  logic       reset,
  dmem_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StRdWait, StDone} state_e;

  state_e        state_q;
  logic          last_ld_q;
  logic          owner_ld_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    funct3_q;
  logic [31:0]   cpu_rdata_q;
  logic [31:0]   ld_rdata_q;
  logic          cpu_ready_q;
  logic          cpu_fault_q;
  logic          ld_valid_q;

  logic          issue;
  logic          grant_ld;
  logic [AW-1:0] win_addr;
  logic          cpu_fault_c;
  logic [3:0]    be_c;
  logic [31:0]   wd_c;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_ext;
  logic          unused_addr_bits;

  // Address bits above AW are not decoded by the memory; loader low bits are word-ignored.
  assign unused_addr_bits = ^{bus_io.cpu_addr[31:AW], bus_io.ld_addr[31:AW],
                              bus_io.ld_addr[1:0]};

  // Arbitration and issue-cycle decode.
  always_comb begin
    issue    = (state_q == StIdle) && (bus_io.cpu_req || bus_io.ld_req);
    grant_ld = bus_io.ld_req && (!bus_io.cpu_req || !last_ld_q);
    win_addr = grant_ld ? {bus_io.ld_addr[AW-1:2], 2'b00} : bus_io.cpu_addr[AW-1:0];

    case (bus_io.cpu_funct3)
      3'b000:  cpu_fault_c = 1'b0;
      3'b001:  cpu_fault_c = bus_io.cpu_addr[0];
      3'b010:  cpu_fault_c = (bus_io.cpu_addr[1:0] != 2'b00);
      3'b100:  cpu_fault_c = bus_io.cpu_we;
      3'b101:  cpu_fault_c = bus_io.cpu_we || bus_io.cpu_addr[0];
      default: cpu_fault_c = 1'b1;
    endcase
  end

  // Write lanes exist only in the issue cycle and never while reset is high.
  always_comb begin
    be_c = 4'b0000;
    wd_c = 32'h0;
    if (issue && !reset) begin
      if (grant_ld) begin
        if (bus_io.ld_we) begin
          be_c = 4'b1111;
          wd_c = bus_io.ld_wdata;
        end
      end else if (bus_io.cpu_we && !cpu_fault_c) begin
        case (bus_io.cpu_funct3[1:0])
          2'b00: begin
            be_c = 4'b0001 << bus_io.cpu_addr[1:0];
            wd_c = {4{bus_io.cpu_wdata[7:0]}};
          end
          2'b01: begin
            be_c = bus_io.cpu_addr[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{bus_io.cpu_wdata[15:0]}};
          end
          default: begin
            be_c = 4'b1111;
            wd_c = bus_io.cpu_wdata;
          end
        endcase
      end
    end
  end

  // Load lane extraction from the address latched at issue.
  always_comb begin
    unique case (addr_q[1:0])
      2'd0: rd_byte = bus_io.mem_rd[7:0];
      2'd1: rd_byte = bus_io.mem_rd[15:8];
      2'd2: rd_byte = bus_io.mem_rd[23:16];
      2'd3: rd_byte = bus_io.mem_rd[31:24];
    endcase
    rd_half = addr_q[1] ? bus_io.mem_rd[31:16] : bus_io.mem_rd[15:0];

    case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = bus_io.mem_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_ld_q   <= 1'b1;
      owner_ld_q  <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= 3'b000;
      cpu_rdata_q <= 32'h0;
      ld_rdata_q  <= 32'h0;
      cpu_ready_q <= 1'b0;
      cpu_fault_q <= 1'b0;
      ld_valid_q  <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      ld_valid_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (issue) begin
            last_ld_q  <= grant_ld;
            owner_ld_q <= grant_ld;
            addr_q     <= win_addr;
            funct3_q   <= bus_io.cpu_funct3;
            if (grant_ld) begin
              if (bus_io.ld_we) begin
                state_q    <= StDone;
                ld_valid_q <= 1'b1;
              end else begin
                state_q <= StRdWait;
              end
            end else if (cpu_fault_c || bus_io.cpu_we) begin
              state_q     <= StDone;
              cpu_ready_q <= 1'b1;
              cpu_fault_q <= cpu_fault_c;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          state_q <= StDone;
          if (owner_ld_q) begin
            ld_rdata_q <= bus_io.mem_rd;
            ld_valid_q <= 1'b1;
          end else begin
            cpu_rdata_q <= load_ext;
            cpu_ready_q <= 1'b1;
            cpu_fault_q <= 1'b0;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // A reset landing on the completion cycle swallows the pulse.
  always_comb begin
    bus_io.mem_addr  = {{(32 - AW){1'b0}}, issue ? win_addr[AW-1:2] : addr_q[AW-1:2], 2'b00};
    bus_io.mem_be    = be_c;
    bus_io.mem_wd    = wd_c;
    bus_io.cpu_rdata = cpu_rdata_q;
    bus_io.cpu_ready = cpu_ready_q && !reset;
    bus_io.cpu_fault = cpu_fault_q;
    bus_io.ld_rdata  = ld_rdata_q;
    bus_io.ld_valid  = ld_valid_q && !reset;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus random bench for dmem_ctrl against a byte-array reference memory.
module tb_dmem_ctrl;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.AW(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  // Physical byte-lane RAM behind the controller.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_be[i]) ram[{bus.mem_addr[9:2], i[1:0]}] <= bus.mem_wd[8*i +: 8];
    end
    bus.mem_rd <= {ram[{bus.mem_addr[9:2], 2'd3}], ram[{bus.mem_addr[9:2], 2'd2}],
                   ram[{bus.mem_addr[9:2], 2'd1}], ram[{bus.mem_addr[9:2], 2'd0}]};
  end

  logic [7:0]  ref_mem [0:1023];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cpu_rdata;
  logic [31:0] exp_ld_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[9:2]) * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int i;
    logic [15:0] h;
    i = int'(a[9:0]);
    h = {ref_mem[(i+1) % 1024], ref_mem[i]};
    case (f3)
      3'b000:  return 32'($signed(ref_mem[i]));
      3'b100:  return {24'h0, ref_mem[i]};
      3'b001:  return 32'($signed(h));
      3'b101:  return {16'h0, h};
      default: return ref_word(a);
    endcase
  endfunction

  function automatic logic exp_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic illegal, bad_store, mis_half, mis_word;
    illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    bad_store = we && (f3 == 3'b100 || f3 == 3'b101);
    mis_half  = (f3[1:0] == 2'b01) && a[0];
    mis_word  = (f3 == 3'b010) && (a[1:0] != 2'b00);
    return illegal || bad_store || mis_half || mis_word;
  endfunction

  task automatic cpu_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    logic        flt;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          size, lat, n;
    flt  = exp_fault(we, f3, a);
    size = 1 << f3[1:0];
    ebe  = 4'b0000;
    ewd  = 32'h0;
    if (we && !flt) begin
      for (int k = 0; k < size; k++) ebe[(int'(a[1:0]) + k) % 4] = 1'b1;
      for (int j = 0; j < 4; j++) ewd[8*j +: 8] = wd[8*(j % size) +: 8];
    end
    lat = (flt || we) ? 1 : 2;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_funct3 = f3;
    bus.cpu_addr = a; bus.cpu_wdata = wd;
    #1;
    check("cpu_issue_be", 32'(bus.mem_be), 32'(ebe));
    check("cpu_issue_wd", bus.mem_wd, ewd);
    check("cpu_issue_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
    check("cpu_ready_idle", 32'(bus.cpu_ready), 32'd0);
    if (we && !flt) begin
      for (int k = 0; k < size; k++) ref_mem[int'(a[9:0]) + k] = wd[8*k +: 8];
    end
    if (!we && !flt) exp_cpu_rdata = ref_load(f3, a);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n++;
      if (bus.cpu_ready === 1'b1) break;
      check("cpu_wait_be", 32'(bus.mem_be), 32'd0);
    end
    check("cpu_latency", 32'(n), 32'(lat));
    check("cpu_fault", 32'(bus.cpu_fault), 32'(flt));
    check("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
    check("cpu_done_be", 32'(bus.mem_be), 32'd0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  task automatic ld_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int lat, n, b;
    lat = we ? 1 : 2;
    b   = int'(a[9:2]) * 4;
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = wd;
    #1;
    check("ld_issue_be", 32'(bus.mem_be), we ? 32'hF : 32'h0);
    check("ld_issue_wd", bus.mem_wd, we ? wd : 32'h0);
    check("ld_issue_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
    if (we) begin
      for (int k = 0; k < 4; k++) ref_mem[b + k] = wd[8*k +: 8];
    end else begin
      exp_ld_rdata = ref_word(a);
    end
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n++;
      if (bus.ld_valid === 1'b1) break;
    end
    check("ld_latency", 32'(n), 32'(lat));
    check("ld_rdata", bus.ld_rdata, exp_ld_rdata);
    @(negedge clk);
    bus.ld_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_cpu_rdata = 32'h0;
    exp_ld_rdata  = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3tbl [0:7];
    int         seq_k, ncyc;
    logic [31:0] a;
    logic [2:0]  f3;
    logic        we;

    f3tbl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b000;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = 32'h0; bus.ld_wdata = 32'h0;
    exp_cpu_rdata = 32'h0;
    exp_ld_rdata  = 32'h0;

    // Reset with a store pending: no write lanes, outputs cleared.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = 3'b010;
    bus.cpu_addr = 32'h8; bus.cpu_wdata = 32'h1234_5678;
    #1;
    check("reset_be_gate", 32'(bus.mem_be), 32'd0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check("reset_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("reset_cpu_fault", 32'(bus.cpu_fault), 32'd0);
    check("reset_ld_valid", 32'(bus.ld_valid), 32'd0);
    check("reset_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("reset_ld_rdata", bus.ld_rdata, 32'h0);
    reset = 1'b0;

    // Zero-fill the working region through the loader (low address bits must be ignored).
    for (int w = 0; w < 64; w++) ld_op(1'b1, 32'(w * 4) | 32'($urandom_range(0, 3)), 32'h0);

    cpu_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    cpu_op(1'b1, 3'b000, 32'h13, 32'h1234_56A5);
    cpu_op(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_value", bus.cpu_rdata, 32'hFFFF_FFA5);
    cpu_op(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_value", bus.cpu_rdata, 32'h0000_00A5);
    cpu_op(1'b1, 3'b001, 32'h22, 32'h0000_8001);
    cpu_op(1'b0, 3'b001, 32'h22, 32'h0);
    check("lh_value", bus.cpu_rdata, 32'hFFFF_8001);
    cpu_op(1'b0, 3'b101, 32'h22, 32'h0);
    check("lhu_value", bus.cpu_rdata, 32'h0000_8001);
    cpu_op(1'b0, 3'b010, 32'h20, 32'h0);
    check("lw_upper_half", bus.cpu_rdata, 32'h8001_0000);
    cpu_op(1'b0, 3'b010, 32'h12, 32'h0);
    cpu_op(1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF);
    cpu_op(1'b0, 3'b011, 32'h10, 32'h0);
    check("fault_keeps_rdata", bus.cpu_rdata, 32'h8001_0000);
    ld_op(1'b0, 32'h10, 32'h0);
    check("ld_read_word", bus.ld_rdata, 32'hA5AD_BEEF);

    // Both ports requesting continuously: completions alternate starting with the CPU.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b010; bus.cpu_addr = 32'h40;
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h47; bus.ld_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) ref_mem[32'h44 + k] = bus.ld_wdata[8*k +: 8];
    seq_k = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.mem_be !== 4'b0000) begin
        check("arb_ld_be", 32'(bus.mem_be), 32'hF);
        check("arb_ld_addr", bus.mem_addr, 32'h44);
        check("arb_ld_wd", bus.mem_wd, 32'hCAFE_F00D);
      end
      @(posedge clk); #1;
      if (bus.cpu_ready === 1'b1 || bus.ld_valid === 1'b1) begin
        check("arb_order", 32'(bus.ld_valid), 32'(seq_k % 2));
        if (bus.cpu_ready === 1'b1) check("arb_cpu_rdata", bus.cpu_rdata, ref_word(32'h40));
        seq_k++;
      end
      if (seq_k == 6) break;
      @(negedge clk);
    end
    check("arb_completions", 32'(seq_k), 32'd6);
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    exp_cpu_rdata = ref_word(32'h40);

    // Reset while a load waits for data: access abandoned, then a fresh load completes.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b010; bus.cpu_addr = 32'h10;
    @(posedge clk); #1;
    reset = 1'b1; bus.cpu_req = 1'b0;
    check("rst_wait_be", 32'(bus.mem_be), 32'd0);
    ncyc = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (bus.cpu_ready === 1'b1) ncyc++;
      check("rst_wait_be_hold", 32'(bus.mem_be), 32'd0);
      if (c == 0) begin
        @(negedge clk);
        reset = 1'b0;
      end
    end
    check("rst_no_ready", 32'(ncyc), 32'd0);
    exp_cpu_rdata = 32'h0;
    check("rst_rdata_clear", bus.cpu_rdata, 32'h0);
    cpu_op(1'b0, 3'b010, 32'h10, 32'h0);

    // Random mix of CPU and loader traffic over the zero-filled region.
    for (int r = 0; r < 80; r++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) begin
        we = 1'($urandom_range(0, 1));
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                         : f3tbl[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << f3[1:0]) - 32'd1);
        cpu_op(we, f3, a, $urandom);
      end else begin
        ld_op(1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
